// File: rtl/fp32_pcpi_issuer_pkg.sv
// rtl/fp32_pcpi_issuer_pkg.sv - shared FP co-processor opcodes, funct codes and issuer state encoding
package fp32_pcpi_issuer_pkg;

  localparam logic [6:0]  OPCODE_CUSTOM0 = 7'b0001011;
  localparam logic [2:0]  FUNCT3_FP      = 3'b000;
  localparam logic [6:0]  F7_FADD        = 7'h00;
  localparam logic [6:0]  F7_FSUB        = 7'h04;
  localparam logic [31:0] FP32_SIGN_MASK = 32'h8000_0000;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ISSUE    = 3'd1;
  localparam logic [2:0] ST_WAIT_RES = 3'd2;
  localparam logic [2:0] ST_RESPOND  = 3'd3;
  localparam logic [2:0] ST_DRAIN    = 3'd4;

  // a - b is issued to the adder as a + (-b)
  function automatic logic [31:0] negate_fp32(input logic [31:0] x);
    return x ^ FP32_SIGN_MASK;
  endfunction

endpackage

// File: rtl/fp32_pcpi_issuer_if.sv
// rtl/fp32_pcpi_issuer_if.sv - PCPI request/response and FP32 adder handshake bundle
interface fp32_pcpi_issuer_if;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        pcpi_ready;
  logic [31:0] fp_input_a;
  logic [31:0] fp_input_b;
  logic        fp_input_STB;
  logic        fp_BUSY;
  logic [31:0] fp_output_sum;
  logic        fp_output_STB;
  logic        fp_output_module_BUSY;

  // master: CPU plus adder environment; slave: the issuer
  modport master (
    output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2, fp_BUSY, fp_output_sum, fp_output_STB,
    input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready, fp_input_a, fp_input_b, fp_input_STB,
           fp_output_module_BUSY
  );

  modport slave (
    input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2, fp_BUSY, fp_output_sum, fp_output_STB,
    output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready, fp_input_a, fp_input_b, fp_input_STB,
           fp_output_module_BUSY
  );
endinterface

// File: rtl/fp32_pcpi_issuer_decode.sv
// rtl/fp32_pcpi_issuer_decode.sv - combinational match of custom-0 FADD/FSUB instructions
module fp32_pcpi_decode
  import fp32_pcpi_issuer_pkg::*;
#(
  parameter logic [6:0] OPCODE = OPCODE_CUSTOM0,
  parameter logic [6:0] F7_ADD = F7_FADD,
  parameter logic [6:0] F7_SUB = F7_FSUB
) (
  input  logic [31:0] insn,
  output logic        match,
  output logic        is_sub
);

  logic [6:0] funct7;
  logic       unused_reg_fields;

  assign funct7 = insn[31:25];
  // register specifiers are irrelevant: operands arrive on rs1/rs2
  assign unused_reg_fields = ^{insn[24:15], insn[11:7]};

  assign is_sub = (funct7 == F7_SUB);
  assign match  = (insn[6:0] == OPCODE) && (insn[14:12] == FUNCT3_FP) &&
                  ((funct7 == F7_ADD) || (funct7 == F7_SUB));

endmodule

// File: rtl/fp32_pcpi_issuer.sv
// rtl/fp32_pcpi_issuer.sv - issues PCPI FADD/FSUB to an external FP32 adder and returns the sum
module fp32_pcpi_issuer
  import fp32_pcpi_issuer_pkg::*;
#(
  parameter logic [6:0] OPCODE = OPCODE_CUSTOM0,
  parameter logic [6:0] F7_ADD = F7_FADD,
  parameter logic [6:0] F7_SUB = F7_FSUB
) (
  input  logic            clk,
  input  logic            resetn,
  fp32_pcpi_issuer_if.slave bus
);

  logic [2:0] state;
  logic       match;
  logic       is_sub;
  logic       in_xfer;
  logic       out_xfer;

  fp32_pcpi_decode #(
    .OPCODE (OPCODE),
    .F7_ADD (F7_ADD),
    .F7_SUB (F7_SUB)
  ) u_decode (
    .insn   (bus.pcpi_insn),
    .match  (match),
    .is_sub (is_sub)
  );

  assign in_xfer  = bus.fp_input_STB && !bus.fp_BUSY;
  assign out_xfer = bus.fp_output_STB && !bus.fp_output_module_BUSY;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state                     <= ST_IDLE;
      bus.pcpi_wr               <= 1'b0;
      bus.pcpi_rd               <= 32'h0;
      bus.pcpi_wait             <= 1'b0;
      bus.pcpi_ready            <= 1'b0;
      bus.fp_input_STB          <= 1'b0;
      bus.fp_input_a            <= 32'h0;
      bus.fp_input_b            <= 32'h0;
      bus.fp_output_module_BUSY <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.pcpi_valid && match) begin
            bus.fp_input_a   <= bus.pcpi_rs1;
            bus.fp_input_b   <= is_sub ? negate_fp32(bus.pcpi_rs2) : bus.pcpi_rs2;
            bus.pcpi_wait    <= 1'b1;
            bus.fp_input_STB <= 1'b1;
            state            <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // once the adder has taken the operands its result must be drained, even on abort
          if (in_xfer) begin
            bus.fp_input_STB          <= 1'b0;
            bus.fp_output_module_BUSY <= 1'b0;
            if (bus.pcpi_valid) begin
              state <= ST_WAIT_RES;
            end else begin
              bus.pcpi_wait <= 1'b0;
              state         <= ST_DRAIN;
            end
          end else if (!bus.pcpi_valid) begin
            bus.fp_input_STB <= 1'b0;
            bus.pcpi_wait    <= 1'b0;
            state            <= ST_IDLE;
          end
        end
        ST_WAIT_RES: begin
          if (out_xfer) begin
            bus.fp_output_module_BUSY <= 1'b1;
            bus.pcpi_wait             <= 1'b0;
            if (bus.pcpi_valid) begin
              bus.pcpi_rd    <= bus.fp_output_sum;
              bus.pcpi_ready <= 1'b1;
              bus.pcpi_wr    <= 1'b1;
              state          <= ST_RESPOND;
            end else begin
              state <= ST_IDLE;
            end
          end else if (!bus.pcpi_valid) begin
            bus.pcpi_wait <= 1'b0;
            state         <= ST_DRAIN;
          end
        end
        ST_RESPOND: begin
          bus.pcpi_ready <= 1'b0;
          bus.pcpi_wr    <= 1'b0;
          state          <= ST_IDLE;
        end
        ST_DRAIN: begin
          if (out_xfer) begin
            bus.fp_output_module_BUSY <= 1'b1;
            state                     <= ST_IDLE;
          end
        end
        default: begin
          bus.fp_output_module_BUSY <= 1'b1;
          state                     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
